// File: rtl/demux_pkg.sv
// Shared constants and helpers for the demux_lanes serial-to-parallel lane demultiplexer.
package demux_pkg;

  localparam int LANES_MAX        = 8;
  localparam int IDLE_VAL_DEFAULT = 0;

  // Width of active_lanes: enough bits to hold the value LANES itself.
  function automatic int act_width(input int lanes);
    return $clog2((lanes > LANES_MAX) ? LANES_MAX : lanes) + 1;
  endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One output lane register; data is forced to IDLE_VAL whenever the lane is not valid.
module demux_lane_reg
  import demux_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] IDLE_VAL = WIDTH'(IDLE_VAL_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    valid_d = ld_valid;
    data_d  = ld_valid ? ld_data : IDLE_VAL;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_q <= 1'b0;
      data_q  <= IDLE_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: rtl/demux_lanes.sv
// Serial word stream to LANES parallel lanes, grouped by a per-group lane count.
// Define DEMUX_LANES_FLUSH_EN to emit partial groups as soon as valid drops.
module demux_lanes
  import demux_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               LANES    = 4,
  parameter logic [WIDTH-1:0] IDLE_VAL = WIDTH'(IDLE_VAL_DEFAULT)
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic                         valid,
  input  logic [WIDTH-1:0]             data_in,
  input  logic [act_width(LANES)-1:0]  active_lanes,
  output logic [LANES-1:0]             valid_out,
  output logic [LANES*WIDTH-1:0]       data_out,
  output logic                         group_done
);

  localparam int AW = act_width(LANES);
  localparam int PW = AW - 1;

  logic [PW-1:0]    ptr_d, ptr_q;
  logic [AW-1:0]    act_d, act_q;
  logic [WIDTH-1:0] stage_d [LANES];
  logic [WIDTH-1:0] stage_q [LANES];
  logic             group_done_d, group_done_q;

  logic [AW-1:0] ptr_ext;
  logic [AW-1:0] act_in;
  logic [AW-1:0] eff_act;
  logic          last;
  logic          flush;

  assign ptr_ext = {1'b0, ptr_q};
  // Out-of-range lane counts fall back to the full lane count.
  assign act_in  = (active_lanes == '0 || active_lanes > AW'(LANES)) ? AW'(LANES) : active_lanes;
  assign eff_act = (valid && ptr_q == '0) ? act_in : act_q;
  assign last    = valid && (ptr_ext == eff_act - AW'(1));

`ifdef DEMUX_LANES_FLUSH_EN
  assign flush = !valid && (ptr_q != '0);
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    ptr_d        = ptr_q;
    act_d        = act_q;
    stage_d      = stage_q;
    group_done_d = last || flush;
    if (valid) begin
      act_d = eff_act;
      if (last) begin
        ptr_d = '0;
      end else begin
        stage_d[ptr_q] = data_in;
        ptr_d          = ptr_q + PW'(1);
      end
    end else if (flush) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr_q        <= '0;
      act_q        <= AW'(LANES);
      group_done_q <= 1'b0;
      for (int i = 0; i < LANES; i++) stage_q[i] <= IDLE_VAL;
    end else begin
      ptr_q        <= ptr_d;
      act_q        <= act_d;
      group_done_q <= group_done_d;
      stage_q      <= stage_d;
    end
  end

  assign group_done = group_done_q;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic             ld_valid;
      logic [WIDTH-1:0] ld_data;

      // The closing word bypasses staging and lands directly on lane act-1.
      always_comb begin
        ld_valid = 1'b0;
        ld_data  = IDLE_VAL;
        if (last) begin
          ld_valid = AW'(gi) < eff_act;
          ld_data  = (AW'(gi) == eff_act - AW'(1)) ? data_in : stage_q[gi];
        end else if (flush) begin
          ld_valid = AW'(gi) < ptr_ext;
          ld_data  = stage_q[gi];
        end
      end

      demux_lane_reg #(
        .WIDTH    (WIDTH),
        .IDLE_VAL (IDLE_VAL)
      ) u_lane (
        .clk       (clk),
        .reset_L   (reset_L),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .valid_out (valid_out[gi]),
        .data_out  (data_out[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_demux_lanes.sv
// Directed, table-driven check of demux_lanes with LANES=4, WIDTH=8, IDLE_VAL=0.
module tb_demux_lanes;

  logic        clk;
  logic        reset_L;
  logic        valid;
  logic [7:0]  data_in;
  logic [2:0]  active_lanes;
  logic [3:0]  valid_out;
  logic [31:0] data_out;
  logic        group_done;

  int n_cmp;
  int n_bad;

  demux_lanes #(
    .WIDTH    (8),
    .LANES    (4),
    .IDLE_VAL (8'h00)
  ) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .valid        (valid),
    .data_in      (data_in),
    .active_lanes (active_lanes),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .group_done   (group_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v;
    logic [7:0]  d;
    logic [2:0]  a;
    logic [3:0]  evo;
    logic [31:0] edo;
    logic        egd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic v, input logic [7:0] d,
                              input logic [2:0] a, input logic [3:0] evo,
                              input logic [31:0] edo, input logic egd);
    vec_t r;
    r.name = name; r.v = v; r.d = d; r.a = a; r.evo = evo; r.edo = edo; r.egd = egd;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input logic [3:0] evo,
                       input logic [31:0] edo, input logic egd);
    n_cmp++;
    if (valid_out !== evo || data_out !== edo || group_done !== egd) begin
      n_bad++;
      $display("FAIL %s: got vo=%b do=%h gd=%b, want vo=%b do=%h gd=%b",
               name, valid_out, data_out, group_done, evo, edo, egd);
    end else begin
      $display("ok   %s: vo=%b do=%h gd=%b", name, valid_out, data_out, group_done);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic [2:0] a);
    valid = v; data_in = d; active_lanes = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    valid = 1'b0; data_in = 8'h00; active_lanes = 3'd4;
    reset_L = 1'b0;

    // Four words, full width
    add("g4_a1", 1, 8'hA1, 3'd4, 4'b0000, 32'h0, 0);
    add("g4_a2", 1, 8'hA2, 3'd4, 4'b0000, 32'h0, 0);
    add("g4_a3", 1, 8'hA3, 3'd4, 4'b0000, 32'h0, 0);
    add("g4_a4", 1, 8'hA4, 3'd4, 4'b1111, 32'hA4A3A2A1, 1);
    add("g4_idle", 0, 8'h00, 3'd4, 4'b0000, 32'h0, 0);
    // Two-lane groups back to back
    add("g2_10", 1, 8'h10, 3'd2, 4'b0000, 32'h0, 0);
    add("g2_11", 1, 8'h11, 3'd2, 4'b0011, 32'h00001110, 1);
    add("g2_12", 1, 8'h12, 3'd2, 4'b0000, 32'h0, 0);
    add("g2_13", 1, 8'h13, 3'd2, 4'b0011, 32'h00001312, 1);
    add("g2_14", 1, 8'h14, 3'd2, 4'b0000, 32'h0, 0);
    add("g2_15", 1, 8'h15, 3'd2, 4'b0011, 32'h00001514, 1);
    add("g2_idle", 0, 8'h00, 3'd2, 4'b0000, 32'h0, 0);
    // Out-of-range lane counts behave as 4
    add("a0_b0", 1, 8'hB0, 3'd0, 4'b0000, 32'h0, 0);
    add("a0_b1", 1, 8'hB1, 3'd0, 4'b0000, 32'h0, 0);
    add("a0_b2", 1, 8'hB2, 3'd0, 4'b0000, 32'h0, 0);
    add("a0_b3", 1, 8'hB3, 3'd0, 4'b1111, 32'hB3B2B1B0, 1);
    add("a7_c0", 1, 8'hC0, 3'd7, 4'b0000, 32'h0, 0);
    add("a7_c1", 1, 8'hC1, 3'd7, 4'b0000, 32'h0, 0);
    add("a7_c2", 1, 8'hC2, 3'd7, 4'b0000, 32'h0, 0);
    add("a7_c3", 1, 8'hC3, 3'd7, 4'b1111, 32'hC3C2C1C0, 1);
    // Lane count changes mid-group, then single-lane groups
    add("chg_d0", 1, 8'hD0, 3'd4, 4'b0000, 32'h0, 0);
    add("chg_d1", 1, 8'hD1, 3'd4, 4'b0000, 32'h0, 0);
    add("chg_d2", 1, 8'hD2, 3'd1, 4'b0000, 32'h0, 0);
    add("chg_d3", 1, 8'hD3, 3'd1, 4'b1111, 32'hD3D2D1D0, 1);
    add("a1_e0", 1, 8'hE0, 3'd1, 4'b0001, 32'h000000E0, 1);
    add("a1_e1", 1, 8'hE1, 3'd1, 4'b0001, 32'h000000E1, 1);
    add("a1_idle", 0, 8'h00, 3'd1, 4'b0000, 32'h0, 0);
    // Three lanes: lane 3 stays idle
    add("a3_f0", 1, 8'hF0, 3'd3, 4'b0000, 32'h0, 0);
    add("a3_f1", 1, 8'hF1, 3'd3, 4'b0000, 32'h0, 0);
    add("a3_f2", 1, 8'hF2, 3'd3, 4'b0111, 32'h00F2F1F0, 1);
    // Partial group followed by a gap
    add("gap_01", 1, 8'h01, 3'd4, 4'b0000, 32'h0, 0);
    add("gap_02", 1, 8'h02, 3'd4, 4'b0000, 32'h0, 0);
`ifdef DEMUX_LANES_FLUSH_EN
    add("gap_i0", 0, 8'h00, 3'd4, 4'b0011, 32'h00000201, 1);
`else
    add("gap_i0", 0, 8'h00, 3'd4, 4'b0000, 32'h0, 0);
`endif
    for (int k = 1; k < 5; k++) add("gap_ix", 0, 8'h00, 3'd4, 4'b0000, 32'h0, 0);
    add("gap_03", 1, 8'h03, 3'd4, 4'b0000, 32'h0, 0);
`ifdef DEMUX_LANES_FLUSH_EN
    add("gap_04", 1, 8'h04, 3'd4, 4'b0000, 32'h0, 0);
    add("gap_end", 0, 8'h00, 3'd4, 4'b0011, 32'h00000403, 1);
`else
    add("gap_04", 1, 8'h04, 3'd4, 4'b1111, 32'h04030201, 1);
    add("gap_end", 0, 8'h00, 3'd4, 4'b0000, 32'h0, 0);
`endif

    // Reset state, with stimulus present that must be ignored
    valid = 1'b1; data_in = 8'h99;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    reset_L = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1;
    check("reset_rel", 4'b0000, 32'h0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].a);
      check(vecs[i].name, vecs[i].evo, vecs[i].edo, vecs[i].egd);
    end

    // Async reset clears a presented group immediately
    step(1, 8'h21, 3'd4);
    step(1, 8'h22, 3'd4);
    step(1, 8'h23, 3'd4);
    step(1, 8'h24, 3'd4);
    check("rst_pre", 4'b1111, 32'h24232221, 1'b1);
    reset_L = 1'b0;
    #1;
    check("rst_async", 4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    reset_L = 1'b1;

    // Partial group discarded by a reset pulse
    step(1, 8'h55, 3'd4);
    step(1, 8'h66, 3'd4);
    valid = 1'b0;
    #2;
    reset_L = 1'b0;
    #2;
    check("rst_mid", 4'b0000, 32'h0, 1'b0);
    reset_L = 1'b1;
    step(1, 8'h11, 3'd4);
    check("post_11", 4'b0000, 32'h0, 1'b0);
    step(1, 8'h12, 3'd4);
    check("post_12", 4'b0000, 32'h0, 1'b0);
    step(1, 8'h13, 3'd4);
    step(1, 8'h14, 3'd4);
    check("post_grp", 4'b1111, 32'h14131211, 1'b1);
    step(0, 8'h00, 3'd4);
    check("post_idle", 4'b0000, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_lanes.md
DEMUX_LANES -- requirements
Module: demux_lanes

Interface
REQ-001 Parameter WIDTH, default 8, bits per data word.
REQ-002 Parameter LANES, default 4, output lane count; legal values 2, 4, 8.
REQ-003 Parameter IDLE_VAL, default 0, value driven on any data_out lane whose valid_out is 0.
REQ-004 clk  input  1  single rising-edge clock for all state.
REQ-005 reset_L  input  1  asynchronous, active-low reset.
REQ-006 valid  input  1  data_in carries a word this cycle.
REQ-007 data_in  input  WIDTH  serial input word.
REQ-008 active_lanes  input  clog2(LANES)+1  lanes per group; sampled at group start.
REQ-009 valid_out  output  LANES  per-lane valid; bit i qualifies lane i.
REQ-010 data_out  output  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
REQ-011 group_done  output  1  one-cycle pulse when a group is presented on the outputs.

Function
REQ-012 Internal lane pointer ptr (0..LANES-1) shall select the staging register written by each valid word.
REQ-013 On valid=1 with ptr=0, active_lanes shall be latched as act; values 0 or >LANES shall be treated as LANES.
REQ-014 On valid=1, data_in shall be written to stage[ptr] and ptr shall increment, unless ptr=act-1.
REQ-015 On valid=1 with ptr=act-1, the next edge shall set data_out[i]=stage[i] for i<act-1 and data_out[act-1]=data_in, set valid_out[i]=1 for i<act and 0 otherwise, pulse group_done, and clear ptr to 0.
REQ-016 Latency from the last word of a group to valid_out shall be exactly 1 clk cycle.
REQ-017 In any cycle with no group emitted, all valid_out bits and group_done shall be 0 and all data_out lanes shall equal IDLE_VAL.
REQ-018 When valid=0 and flush is not triggered, ptr, act and stage shall hold their values.
REQ-019 Back-to-back groups with valid held high shall be accepted without a bubble.
REQ-020 A new act latched at the start of the next group shall not affect the group being emitted.
REQ-021 With act=1, every valid word shall produce a group on lane 0 only, one cycle later.
REQ-022 Lanes i>=act shall carry IDLE_VAL while a group is presented.

Reset
REQ-023 While reset_L=0: ptr=0, act=LANES, stage=IDLE_VAL, valid_out=0, data_out=IDLE_VAL on all lanes, group_done=0.
REQ-024 Reset asserted mid-group shall discard the partial group, and no output shall result from it.
REQ-025 The first valid word after reset_L rises shall be treated as a group start.

Configuration
REQ-026 Macro DEMUX_LANES_FLUSH_EN shall control partial-group flush.
REQ-027 With DEMUX_LANES_FLUSH_EN defined, valid=0 with ptr!=0 shall, on the next edge, emit stage[i] with valid_out[i]=1 for i<ptr (others 0 / IDLE_VAL), pulse group_done, and clear ptr.
REQ-028 Without DEMUX_LANES_FLUSH_EN, partial groups shall be held indefinitely per REQ-018 and shall complete when further valid words arrive.

Structure
REQ-029 Shared package demux_pkg shall hold LANES_MAX (8), the default IDLE_VAL, and the active_lanes width function.
REQ-030 The per-lane output register with IDLE_VAL gating shall be a sub-module, demux_lane_reg, instantiated LANES times.
REQ-031 The pointer, act latch and flush control shall remain in demux_lanes.

Verification
REQ-032 LANES=4, act=4: valid words 0xA1,0xA2,0xA3,0xA4 -> one cycle later data_out={0xA4,0xA3,0xA2,0xA1}, valid_out=4'b1111, group_done=1 for 1 cycle.
REQ-033 act=2, 6 continuous valid words 0x10..0x15 -> three groups on consecutive-odd cycles, lanes0/1 = (0x10,0x11),(0x12,0x13),(0x14,0x15), valid_out=4'b0011, lanes 2/3 = 0x00.
REQ-034 0x01,0x02 then valid=0 for 5 cycles then 0x03,0x04 -> with FLUSH_EN: group valid_out=4'b0011 (0x01,0x02), then later 2-lane partial after 0x04; without FLUSH_EN: a single group 0x01..0x04.
REQ-035 reset_L pulsed low after 0x55,0x66 -> all outputs 0 asynchronously; next 4 words 0x11..0x14 form a group starting on lane 0.
REQ-036 act changed from 4 to 1 mid-group -> current group completes with 4 lanes; following words emit singly on lane 0, valid_out=4'b0001.
REQ-037 active_lanes=0 and active_lanes=7 with LANES=4 -> both behave as act=4.
